// File: rtl/core_pkg.sv
// Shared definitions for the RV32i core fetch path: FSM state encoding,
// reset-PC default and PC increment. The TRAP state exists only when
// PC_MISALIGN_TRAP_EN is defined.
package core_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int unsigned PC_INCR          = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_HOLD    = 3'd2,
`ifdef PC_MISALIGN_TRAP_EN
        ST_DISCARD = 3'd3,
        ST_TRAP    = 3'd4
`else
        ST_DISCARD = 3'd3
`endif
    } fetch_state_t;

endpackage

// File: rtl/core_fetch_sequencer.sv
// Fetch-stage sequencer: owns the PC, issues one instruction-memory request
// at a time and hands fetched words to decode over valid/ready. Redirects
// from the branch unit override sequential flow and drop in-flight data.
// Optional feature macro: PC_MISALIGN_TRAP_EN (misaligned redirects trap
// instead of being forced aligned).
module core_fetch_sequencer
    import core_pkg::*;
#(
    parameter int unsigned             DATA_WIDTH  = 32,
    parameter int unsigned             INSTR_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0]   RESET_PC    = DATA_WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   redirect_valid_i,
    input  logic [DATA_WIDTH-1:0]  redirect_pc_i,
    output logic                   imem_req_o,
    output logic [DATA_WIDTH-1:0]  imem_addr_o,
    input  logic                   imem_ack_i,
    input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
    output logic                   instr_valid_o,
    input  logic                   instr_ready_i,
    output logic [INSTR_WIDTH-1:0] instr_o,
`ifdef PC_MISALIGN_TRAP_EN
    output logic [DATA_WIDTH-1:0]  instr_pc_o,
    output logic                   misalign_o,
    output logic [DATA_WIDTH-1:0]  misalign_pc_o
`else
    output logic [DATA_WIDTH-1:0]  instr_pc_o
`endif
);

    localparam logic [DATA_WIDTH-1:0] INCR       = DATA_WIDTH'(PC_INCR);
    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);

    fetch_state_t            state_q, state_d;
    logic [DATA_WIDTH-1:0]   req_addr_q, req_addr_d;
    logic [DATA_WIDTH-1:0]   next_pc_q, next_pc_d;
    logic [INSTR_WIDTH-1:0]  instr_q, instr_d;
    logic [DATA_WIDTH-1:0]   instr_pc_q, instr_pc_d;
    logic [DATA_WIDTH-1:0]   target;
    logic                    jump;
    logic [DATA_WIDTH-1:0]   jump_pc;
`ifdef PC_MISALIGN_TRAP_EN
    logic [DATA_WIDTH-1:0]   misalign_pc_q, misalign_pc_d;

    assign target = redirect_pc_i;
`else
    assign target = redirect_pc_i & ALIGN_MASK;
`endif

    // Next-state and next-address logic; all redirect destinations funnel
    // through jump/jump_pc so the alignment decision lives in one place.
    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        next_pc_d  = next_pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        jump       = 1'b0;
        jump_pc    = target;
`ifdef PC_MISALIGN_TRAP_EN
        misalign_pc_d = misalign_pc_q;
`endif
        case (state_q)
            ST_IDLE: begin
                req_addr_d = RESET_PC;
                next_pc_d  = RESET_PC;
                state_d    = ST_REQ;
            end
            ST_REQ: begin
                if (redirect_valid_i) begin
                    if (imem_ack_i) begin
                        jump = 1'b1;
                    end else begin
                        next_pc_d = target;
                        state_d   = ST_DISCARD;
                    end
                end else if (imem_ack_i) begin
                    instr_d    = imem_rdata_i;
                    instr_pc_d = req_addr_q;
                    state_d    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (redirect_valid_i) begin
                    jump = 1'b1;
                end else if (instr_ready_i) begin
                    req_addr_d = instr_pc_q + INCR;
                    next_pc_d  = instr_pc_q + INCR;
                    state_d    = ST_REQ;
                end
            end
            ST_DISCARD: begin
                if (imem_ack_i) begin
                    jump    = 1'b1;
                    jump_pc = redirect_valid_i ? target : next_pc_q;
                end else if (redirect_valid_i) begin
                    next_pc_d = target;
                end
            end
`ifdef PC_MISALIGN_TRAP_EN
            ST_TRAP: begin
                if (redirect_valid_i) begin
                    jump = 1'b1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        if (jump) begin
`ifdef PC_MISALIGN_TRAP_EN
            if (jump_pc[1:0] != 2'b00) begin
                misalign_pc_d = jump_pc;
                state_d       = ST_TRAP;
            end else begin
                req_addr_d = jump_pc;
                next_pc_d  = jump_pc;
                state_d    = ST_REQ;
            end
`else
            req_addr_d = jump_pc;
            next_pc_d  = jump_pc;
            state_d    = ST_REQ;
`endif
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            req_addr_q <= RESET_PC;
            next_pc_q  <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= '0;
`ifdef PC_MISALIGN_TRAP_EN
            misalign_pc_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            next_pc_q  <= next_pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
`ifdef PC_MISALIGN_TRAP_EN
            misalign_pc_q <= misalign_pc_d;
`endif
        end
    end

    assign imem_req_o    = (state_q == ST_REQ) || (state_q == ST_DISCARD);
    assign imem_addr_o   = req_addr_q;
    assign instr_valid_o = (state_q == ST_HOLD);
    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;
`ifdef PC_MISALIGN_TRAP_EN
    assign misalign_o    = (state_q == ST_TRAP);
    assign misalign_pc_o = misalign_pc_q;
`endif

endmodule

// File: tb/tb_core_fetch_sequencer.sv
// Directed testbench for core_fetch_sequencer. Inputs are driven and
// outputs sampled 1 time unit after each rising edge.
module tb_core_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
`ifdef PC_MISALIGN_TRAP_EN
    logic        misalign;
    logic [31:0] misalign_pc;
`endif

    int checks = 0;
    int errors = 0;

    core_fetch_sequencer #(
        .DATA_WIDTH (32),
        .INSTR_WIDTH(32),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .redirect_valid_i(redirect_valid),
        .redirect_pc_i   (redirect_pc),
        .imem_req_o      (imem_req),
        .imem_addr_o     (imem_addr),
        .imem_ack_i      (imem_ack),
        .imem_rdata_i    (imem_rdata),
        .instr_valid_o   (instr_valid),
        .instr_ready_i   (instr_ready),
        .instr_o         (instr),
`ifdef PC_MISALIGN_TRAP_EN
        .instr_pc_o      (instr_pc),
        .misalign_o      (misalign),
        .misalign_pc_o   (misalign_pc)
`else
        .instr_pc_o      (instr_pc)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %0b exp 0", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", imem_addr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b exp 0", instr_valid); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL rst_instr got %h exp 0", instr); end
        checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp 0", instr_pc); end
`ifdef PC_MISALIGN_TRAP_EN
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL rst_misalign got %0b exp 0", misalign); end
        checks++; if (misalign_pc !== 32'h0) begin errors++; $display("FAIL rst_misalign_pc got %h exp 0", misalign_pc); end
`endif
        // cycle 1 after release: IDLE, no request
        rst = 1'b0;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL cyc1_req got %0b exp 0", imem_req); end
        step();
        // cycle 2: request at reset PC, zero-wait ack
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL cyc2_req got %0b/%h exp 1/0", imem_req, imem_addr); end
        imem_ack = 1'b1; imem_rdata = 32'h0000_0013;
        step();
        imem_ack = 1'b0;
        checks++; if (instr_valid !== 1'b1 || instr !== 32'h13 || instr_pc !== 32'h0) begin errors++; $display("FAIL cyc3_out got %0b/%h/%h exp 1/00000013/0", instr_valid, instr, instr_pc); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL cyc3_noreq got %0b exp 0", imem_req); end
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4 || instr_valid !== 1'b0) begin errors++; $display("FAIL next_req got %0b/%h/%0b exp 1/4/0", imem_req, imem_addr, instr_valid); end
    endtask

    task automatic test_wait_stall();
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL wait_addr%0d got %0b/%h exp 1/4", i, imem_req, imem_addr); end
        end
        imem_ack = 1'b1; imem_rdata = 32'hAAAA_0001;
        step();
        imem_ack = 1'b0; imem_rdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (instr_valid !== 1'b1 || instr !== 32'hAAAA_0001 || instr_pc !== 32'h4) begin errors++; $display("FAIL stall_out%0d got %0b/%h/%h exp 1/aaaa0001/4", i, instr_valid, instr, instr_pc); end
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_noreq%0d got %0b exp 0", i, imem_req); end
            if (i == 2) instr_ready = 1'b1;
            step();
        end
        instr_ready = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("FAIL stall_next got %0b/%h exp 1/8", imem_req, imem_addr); end
    endtask

    task automatic test_redirect_hold();
        imem_ack = 1'b1; imem_rdata = 32'h0000_0888;
        step();
        imem_ack = 1'b0;
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h8) begin errors++; $display("FAIL hold8 got %0b/%h exp 1/8", instr_valid, instr_pc); end
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        step();
        redirect_valid = 1'b0;
        checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL redir_hold got %0b/%0b/%h exp 0/1/100", instr_valid, imem_req, imem_addr); end
        imem_ack = 1'b1; imem_rdata = 32'h0000_0100;
        step();
        imem_ack = 1'b0;
        checks++; if (instr_pc !== 32'h100 || instr !== 32'h100) begin errors++; $display("FAIL redir_fetch got %h/%h exp 100/100", instr_pc, instr); end
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        checks++; if (imem_addr !== 32'h104) begin errors++; $display("FAIL redir_seq got %h exp 104", imem_addr); end
    endtask

    task automatic test_discard();
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        step();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h104) begin errors++; $display("FAIL disc_hold1 got %0b/%h exp 1/104", imem_req, imem_addr); end
        redirect_pc = 32'h300;
        step();
        redirect_valid = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h104) begin errors++; $display("FAIL disc_hold2 got %0b/%h exp 1/104", imem_req, imem_addr); end
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h300 || instr_valid !== 1'b0) begin errors++; $display("FAIL disc_next got %0b/%h/%0b exp 1/300/0", imem_req, imem_addr, instr_valid); end
        // redirect coincident with ack in REQ: data dropped
        redirect_valid = 1'b1; redirect_pc = 32'h400;
        step();
        redirect_valid = 1'b0; imem_ack = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h400 || instr_valid !== 1'b0) begin errors++; $display("FAIL req_ack_redir got %0b/%h/%0b exp 1/400/0", imem_req, imem_addr, instr_valid); end
        checks++; if (instr === 32'hDEAD_BEEF) begin errors++; $display("FAIL disc_drop got %h exp not deadbeef", instr); end
    endtask

    task automatic test_wrap();
        imem_ack = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req got %h exp fffffffc", imem_addr); end
        imem_rdata = 32'h1234_5678;
        step();
        imem_ack = 1'b0;
        checks++; if (instr_pc !== 32'hFFFF_FFFC || instr !== 32'h1234_5678) begin errors++; $display("FAIL wrap_hold got %h/%h exp fffffffc/12345678", instr_pc, instr); end
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next got %0b/%h exp 1/0", imem_req, imem_addr); end
    endtask

    task automatic test_misalign();
        redirect_valid = 1'b1; redirect_pc = 32'h102; imem_ack = 1'b1;
        step();
        redirect_valid = 1'b0; imem_ack = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
        checks++; if (misalign !== 1'b1 || misalign_pc !== 32'h102 || imem_req !== 1'b0) begin errors++; $display("FAIL trap got %0b/%h/%0b exp 1/102/0", misalign, misalign_pc, imem_req); end
        step();
        checks++; if (misalign !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL trap_stay got %0b/%0b exp 1/0", misalign, imem_req); end
        redirect_valid = 1'b1; redirect_pc = 32'h104;
        step();
        redirect_valid = 1'b0;
        checks++; if (misalign !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h104) begin errors++; $display("FAIL trap_exit got %0b/%0b/%h exp 0/1/104", misalign, imem_req, imem_addr); end
`else
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL align_force got %0b/%h exp 1/100", imem_req, imem_addr); end
`endif
    endtask

    task automatic test_mid_reset();
        rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h5555_5555;
        step();
        checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || imem_addr !== 32'h0) begin errors++; $display("FAIL midrst got %0b/%0b/%h exp 0/0/0", imem_req, instr_valid, imem_addr); end
        rst = 1'b0;
        step();
        checks++; if (imem_req !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== 32'h0) begin errors++; $display("FAIL midrst_idle_ack got %0b/%0b/%h exp 1/0/0", imem_req, instr_valid, imem_addr); end
        step();
        imem_ack = 1'b0;
        checks++; if (instr_valid !== 1'b1 || instr !== 32'h5555_5555 || instr_pc !== 32'h0) begin errors++; $display("FAIL midrst_fetch got %0b/%h/%h exp 1/55555555/0", instr_valid, instr, instr_pc); end
    endtask

    initial begin
        test_reset();
        test_wait_stall();
        test_redirect_hold();
        test_discard();
        test_wrap();
        test_misalign();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_fetch_sequencer.md
# core_fetch_sequencer

Fetch-stage sequencer for the RV32i core: owns the program counter, issues one instruction-memory request at a time, and presents fetched instructions to decode through a valid/ready handshake. Taken-branch and jump targets resolved by the execution unit's branch logic enter as a redirect. The redirect overrides sequential PC+4 flow and discards any in-flight or held fetch. The block sits between the instruction-memory port and the decode stage.

## Interface
- DATA_WIDTH, 32, PC and address width
- INSTR_WIDTH, 32, instruction word width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk_i  in  1  core clock; all logic is rising-edge
- rst_i  in  1  reset; synchronous and active-high
- redirect_valid_i  in  1  execution unit resolved a taken branch or jump this cycle
- redirect_pc_i  in  DATA_WIDTH  redirect target (branch unit new PC)
- imem_req_o  out  1  fetch request; held high until acknowledged
- imem_addr_o  out  DATA_WIDTH  fetch address; stable while imem_req_o is high
- imem_ack_i  in  1  memory accepted the request; imem_rdata_i is valid in the same cycle
- imem_rdata_i  in  INSTR_WIDTH  fetched word
- instr_valid_o  out  1  instr_o and instr_pc_o are valid
- instr_ready_i  in  1  decode accepts the instruction
- instr_o  out  INSTR_WIDTH  instruction to decode
- instr_pc_o  out  DATA_WIDTH  PC of instr_o
- misalign_o  out  1  misaligned redirect trapped (only when PC_MISALIGN_TRAP_EN is defined)
- misalign_pc_o  out  DATA_WIDTH  offending target (only when PC_MISALIGN_TRAP_EN is defined)

## Operation
- Registers:
  - state_q
  - req_addr_q: address of the outstanding request
  - next_pc_q: address of the next request
  - instruction/PC output registers
- State IDLE: entered on reset; exactly one cycle; next_pc_q = RESET_PC; then REQ.
- State REQ:
  - imem_req_o=1 and imem_addr_o=req_addr_q.
  - On imem_ack_i: capture imem_rdata_i into instr_o and req_addr_q into instr_pc_o, then go to HOLD.
- State HOLD:
  - instr_valid_o=1.
  - On instr_valid_o && instr_ready_i: go to REQ with req_addr_q = instr_pc_o + 4.
- State DISCARD:
  - Entered when a redirect arrives in REQ without an ack in that cycle.
  - Keeps imem_req_o=1 and the old address until imem_ack_i; the returned data is dropped.
  - Then goes to REQ with req_addr_q = next_pc_q.
- redirect_valid_i has priority over all sequential flow:
  - REQ with ack in the same cycle: drop the data; next state REQ at redirect_pc_i.
  - REQ without ack: next_pc_q = redirect_pc_i; go to DISCARD.
  - HOLD: instr_valid_o deasserts next cycle; go to REQ at redirect_pc_i. If instr_ready_i is also high, that transfer still counts as completed.
  - DISCARD: next_pc_q = redirect_pc_i; the latest redirect wins.
  - IDLE: the redirect is ignored.
- Arithmetic: PC+4 wraps modulo 2^DATA_WIDTH with no carry-out; 32'hFFFF_FFFC is followed by 32'h0000_0000.
- Only one request is outstanding at any time; there is no prefetch.

## Timing
- Reset values:
  - imem_req_o=0, imem_addr_o=RESET_PC
  - instr_valid_o=0, instr_o=0, instr_pc_o=0
  - misalign_o=0, misalign_pc_o=0
- First imem_req_o rises in the 2nd cycle after rst_i deasserts.
- Fetch latency:
  - Ack in cycle N (the same cycle as the request) gives instr_valid_o in N+1.
  - Each extra wait cycle adds one cycle.
- Back-to-back throughput with zero-wait memory: one instruction every 2 cycles (REQ, HOLD).
- Redirect in cycle N: request to the target is high in N+1 (REQ/HOLD cases), or in the cycle after the discarded ack (DISCARD case).
- rst_i asserted mid-transaction: the block returns to IDLE at the next edge; any imem_ack_i arriving in IDLE is ignored.
- All outputs are registered or decoded from state_q only; there is no combinational path from inputs to outputs.

## Configuration
- PC_MISALIGN_TRAP_EN defined:
  - A redirect with redirect_pc_i[1:0] != 0 enters state TRAP instead of fetching.
  - TRAP drives imem_req_o=0, misalign_o=1, misalign_pc_o=target.
  - TRAP exits to REQ only on a redirect with an aligned target.
  - A misaligned redirect during DISCARD enters TRAP after the pending ack.
- PC_MISALIGN_TRAP_EN undefined:
  - The misalign ports and TRAP state are absent.
  - Redirect targets are forced aligned ({redirect_pc_i[DATA_WIDTH-1:2], 2'b00}).

## Structure
- Shared package core_pkg holds:
  - the state encoding (IDLE, REQ, HOLD, DISCARD, TRAP)
  - the RESET_PC default
  - PC_INCR=4
- Single module; no sub-module is warranted. Next-state and next-address logic is one combinational block feeding the registers.

## Test plan
- Reset release with zero-wait memory returning 32'h0000_0013 -> request at 0x0 in cycle 2; instr_valid_o with instr_pc_o=0x0 in cycle 3; next request at 0x4.
- imem_ack_i delayed 3 cycles and instr_ready_i held low 2 cycles -> imem_addr_o stable through the wait; instr_o stable through the stall; no second request issued.
- Redirect to 0x100 while HOLD holds PC 0x8 -> instr_valid_o drops next cycle; next request at 0x100; 0xC is never fetched.
- Redirect to 0x200 in REQ before ack, then a second redirect to 0x300 before ack -> returned data dropped; next request at 0x300.
- PC at 0xFFFF_FFFC accepted -> next request at 0x0000_0000.
- With PC_MISALIGN_TRAP_EN, redirect to 0x102 -> misalign_o=1 and misalign_pc_o=0x102 with no request; a later redirect to 0x104 resumes fetch at 0x104. Without the macro, the same 0x102 redirect fetches 0x100.
